// File: rtl/pulse_emitter.sv
// Drives a captured WIDTH-bit pattern onto the trigger lines as one pulse with programmable delay/width/holdoff.
// Optional accepted-fire counter: define PULSE_EMITTER_COUNT_EN; otherwise fired_count is tied to zero.
module pulse_emitter #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 8
) (
    input  logic             sampling_clk,
    input  logic             rst,
    input  logic             fire,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] holdoff,
    output logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             overrun,
    output logic [31:0]      fired_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wm1_q, wm1_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] wm1_in;

    // Pulse length minus one, with a zero width stretched to a single cycle.
    assign wm1_in = (width == '0) ? '0 : (width - CNT_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wm1_d   = wm1_q;
        hold_d  = hold_q;
        pat_d   = pat_q;
        out_d   = '0;
        ovr_d   = ovr_q | (fire && (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    pat_d  = pattern;
                    wm1_d  = wm1_in;
                    hold_d = holdoff;
                    if (delay == '0) begin
                        state_d = S_PULSE;
                        cnt_d   = wm1_in;
                        out_d   = pattern;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = delay - CNT_ONE;
                    end
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = wm1_q;
                    out_d   = pat_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    if (hold_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = hold_q - CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    out_d = pat_q;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sampling_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wm1_q   <= '0;
            hold_q  <= '0;
            pat_q   <= '0;
            out_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wm1_q   <= wm1_d;
            hold_q  <= hold_d;
            pat_q   <= pat_d;
            out_q   <= out_d;
            ovr_q   <= ovr_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign done    = (state_q == S_DONE);
    assign out     = out_q;
    assign overrun = ovr_q;

`ifdef PULSE_EMITTER_COUNT_EN
    logic        accept;
    logic [31:0] fired_q;

    assign accept = fire && (state_q == S_IDLE);

    always_ff @(posedge sampling_clk) begin
        if (rst) begin
            fired_q <= 32'h0;
        end else if (accept) begin
            fired_q <= fired_q + 32'd1;
        end
    end

    assign fired_count = fired_q;
`else
    assign fired_count = 32'h0;
`endif

endmodule

// File: tb/tb_pulse_emitter.sv
// Scoreboard bench for pulse_emitter: each accepted fire pushes its expected pulse/done timing,
// and a negedge monitor pops and compares when done strobes.
module tb_pulse_emitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fire = 1'b0;
    logic [23:0] pattern = '0;
    logic [7:0]  delay = '0;
    logic [7:0]  width = '0;
    logic [7:0]  holdoff = '0;
    logic        ready;
    logic [23:0] out;
    logic        done;
    logic        overrun;
    logic [31:0] fired_count;

    pulse_emitter #(.WIDTH(24), .CNT_W(8)) dut (
        .sampling_clk(clk),
        .rst         (rst),
        .fire        (fire),
        .pattern     (pattern),
        .delay       (delay),
        .width       (width),
        .holdoff     (holdoff),
        .ready       (ready),
        .out         (out),
        .done        (done),
        .overrun     (overrun),
        .fired_count (fired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] pat;
        int          start;
        int          len;
        int          done_c;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   exp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: measures the observed pulse and checks it against the scoreboard on done.
    bit          in_pulse = 0;
    bit          rdy_nxt = 0;
    int          obs_st = 0;
    int          obs_len = 0;
    logic [23:0] obs_val = '0;

    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 0;
            rdy_nxt  = 0;
            obs_st   = 0;
            obs_len  = 0;
            obs_val  = '0;
        end else begin
            if (rdy_nxt) begin
                chk("ready_after_done", 32'(ready), 32'd1);
                rdy_nxt = 0;
            end
            if (out != '0) begin
                if (!in_pulse) begin
                    in_pulse = 1;
                    obs_st   = cyc;
                    obs_len  = 0;
                    obs_val  = out;
                end else begin
                    chk("out_stable", 32'(out), 32'(obs_val));
                end
                obs_len++;
            end else begin
                in_pulse = 0;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.done_c));
                    chk("ready_during_done", 32'(ready), 32'd0);
                    chk("pulse_len", 32'(obs_len), 32'(e.len));
                    chk("pulse_pattern", 32'(obs_val), 32'(e.pat));
                    if (e.pat != '0) chk("pulse_start", 32'(obs_st), 32'(e.start));
                    rdy_nxt = 1;
                end
                obs_st  = 0;
                obs_len = 0;
                obs_val = '0;
            end
        end
    end

    // Presents one fire for a single edge; expectations are pushed only if it will be accepted.
    task automatic fire_cmd(input logic [23:0] p, input int d, input int w, input int h);
        bit   acc;
        int   wp;
        exp_t e;
        @(negedge clk);
        acc     = ready;
        pattern = p;
        delay   = 8'(d);
        width   = 8'(w);
        holdoff = 8'(h);
        fire    = 1'b1;
        @(posedge clk);
        #1;
        fire = 1'b0;
        if (acc) begin
            wp       = (w == 0) ? 1 : w;
            e.pat    = p;
            e.start  = cyc + d;
            e.len    = (p == '0) ? 0 : wp;
            e.done_c = cyc + d + wp + h;
            sb.push_back(e);
            exp_cnt++;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && (sb.size() != 0 || !ready); i++) @(negedge clk);
        if (sb.size() != 0 || !ready) begin
            chk("idle_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic chk_count();
`ifdef PULSE_EMITTER_COUNT_EN
        chk("fired_count", fired_count, 32'(exp_cnt));
`else
        chk("fired_count", fired_count, 32'd0);
`endif
    endtask

    initial begin
        int n_done;
        int k;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_fired_count", fired_count, 32'd0);

        // Reset in the middle of a pulse, with a busy fire first so overrun must clear
        fire_cmd(24'hFFFFFF, 1, 10, 2);
        fire_cmd(24'h123456, 0, 1, 0);
        k = 0;
        while (out == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("midpulse_reached", 32'(out), 32'hFFFFFF);
        chk("midpulse_overrun", 32'(overrun), 32'd1);
        rst = 1'b1;
        sb.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_count", fired_count, 32'd0);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midrst_no_done", 32'(n_done), 32'd0);

        // Nominal pulse, plus a busy fire at E0+3 with different parameters
        fire_cmd(24'hA5A5A5, 2, 3, 4);
        repeat (2) @(negedge clk);
        fire_cmd(24'h5A5A5A, 0, 7, 0);
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_idle();
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Minimum timing, zero width stretched to one cycle
        fire_cmd(24'h000001, 0, 0, 0);
        wait_idle();

        // Zero pattern still completes
        fire_cmd(24'h000000, 3, 2, 1);
        wait_idle();

        for (int i = 0; i < 3; i++) begin
            fire_cmd(24'($urandom), $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3));
            wait_idle();
        end

        // Back-to-back fires: second is rejected
        fire_cmd(24'h800000, 1, 1, 1);
        fire_cmd(24'h0F0F0F, 0, 1, 0);
        wait_idle();
        chk("overrun_final", 32'(overrun), 32'd1);
        chk_count();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
